control_fsm: RTL

Parametrised multi-cycle controller for the multi-period MIPS core. It sequences IF → ID → EX → MEM → WB from the decoded opcode and holds the state in its own register. Compared with the previous controller it adds: ready handshakes for instruction and data memory, a data-memory timeout, a sticky error state for illegal opcodes, a global stall, and retire/cycle performance counters. It sits between the instruction register and the datapath enables (PC, register file, data memory).

---
 rtl/control_fsm_pkg.sv | 33 +++
 rtl/control_fsm_perf_counter.sv | 24 ++
 rtl/control_fsm.sv | 115 +++++++++++
 3 files changed

// File: rtl/control_fsm_pkg.sv
// State encoding, MIPS opcodes and opcode classification shared by the
// multi-cycle controller and its bench-facing top.
package control_fsm_pkg;

    localparam int STATE_LEN = 3;

    typedef enum logic [STATE_LEN-1:0] {
        STATE_IF  = 3'd0,
        STATE_ID  = 3'd1,
        STATE_EX  = 3'd2,
        STATE_MEM = 3'd3,
        STATE_WB  = 3'd4,
        STATE_ERR = 3'd7
    } state_e;

    localparam logic [5:0] OP_R_TYPE = 6'b000000;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    // Instructions that finish with a register write-back straight from EX.
    function automatic logic is_alu_op(input logic [5:0] op);
        return (op == OP_R_TYPE) || (op == OP_ADDI) || (op == OP_ORI);
    endfunction

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/control_fsm_perf_counter.sv
// Free-running wrap-around event counter used for cycle and retire statistics.
module ctrl_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (en_i && inc_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer with memory handshakes, MEM timeout,
// sticky illegal-opcode error, global stall and performance counters.
module control_fsm
    import control_fsm_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter bit USE_READY   = 1'b1,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           opcode_i,
    input  logic                 stall_i,
    input  logic                 imem_ready_i,
    input  logic                 dmem_ready_i,
    output logic [STATE_LEN-1:0] state_o,
    output logic                 imem_req_o,
    output logic                 ir_en_o,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    output logic                 reg_rd_o,
    output logic                 reg_we_o,
    output logic                 retire_o,
    output logic                 err_o,
    output logic [CNT_W-1:0]     cycle_cnt_o,
    output logic [CNT_W-1:0]     instret_cnt_o
);

    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              if_ready, mem_ready, retire;

    assign if_ready  = USE_READY ? imem_ready_i : 1'b1;
    assign mem_ready = USE_READY ? dmem_ready_i : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= STATE_IF;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        if (!stall_i) begin
            case (state_q)
                STATE_IF:  if (if_ready) state_d = STATE_ID;
                STATE_ID: begin
                    if (opcode_i == OP_J)                                state_d = STATE_IF;
                    else if (is_alu_op(opcode_i) || is_mem_op(opcode_i)
                             || opcode_i == OP_BEQ)                      state_d = STATE_EX;
                    else                                                 state_d = STATE_ERR;
                end
                STATE_EX: begin
                    wait_cnt_d = '0;
                    if (is_alu_op(opcode_i))       state_d = STATE_WB;
                    else if (is_mem_op(opcode_i))  state_d = STATE_MEM;
                    else if (opcode_i == OP_BEQ)   state_d = STATE_IF;
                    else                           state_d = STATE_ERR;
                end
                STATE_MEM: begin
                    // A late ready beats the timeout on the same edge.
                    if (mem_ready) begin
                        state_d    = (opcode_i == OP_LW) ? STATE_WB : STATE_IF;
                        wait_cnt_d = '0;
                    end else if (MEM_TIMEOUT > 0 && wait_cnt_q == WAIT_LAST) begin
                        state_d    = STATE_ERR;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
                STATE_WB:  state_d = STATE_IF;
                default:   state_d = STATE_ERR;
            endcase
        end
    end

    // Stall already freezes state_d, so it also suppresses retire here.
    assign retire = (state_q != STATE_IF) && (state_q != STATE_ERR) && (state_d == STATE_IF);

    assign state_o    = state_q;
    assign imem_req_o = rst_n && (state_q == STATE_IF);
    assign ir_en_o    = rst_n && (state_q == STATE_IF) && if_ready && !stall_i;
    assign dmem_req_o = rst_n && (state_q == STATE_MEM);
    assign dmem_we_o  = rst_n && (state_q == STATE_MEM) && (opcode_i == OP_SW);
    assign reg_rd_o   = rst_n && (state_q == STATE_ID);
    assign reg_we_o   = rst_n && (state_q == STATE_WB) && !stall_i;
    assign retire_o   = rst_n && !stall_i && retire;
    assign err_o      = rst_n && (state_q == STATE_ERR);

    ctrl_perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (1'b1),
        .en_i  (state_q != STATE_ERR),
        .cnt_o (cycle_cnt_o)
    );

    ctrl_perf_counter #(.CNT_W(CNT_W)) u_instret_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (retire_o),
        .en_i  (1'b1),
        .cnt_o (instret_cnt_o)
    );

endmodule
